// File: rtl/fetch_pair_enqueuer.sv
// Producer side of the 2-wide instruction FIFO: fetches aligned 64-bit pairs,
// one request outstanding, and enqueues one or two instructions per response.
module fetch_pair_enqueuer #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_addr,
  input  logic        io_mem_resp_valid,
  input  logic [63:0] io_mem_resp_data,
  input  logic        io_readyForEnqueue,
  output logic        io_enqueue_0_valid,
  output logic [31:0] io_enqueue_0_bits,
  output logic        io_enqueue_1_valid,
  output logic [31:0] io_enqueue_1_bits
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ENQ} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        drop_reg, drop_next;
  logic        odd_reg, odd_next;
  logic [63:0] hold_reg, hold_next;
  logic        live_reg;

  logic req_fire;
  logic enq_fire;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^io_redirect_pc[1:0];

  // live_reg keeps the request port quiet while reset is held low.
  assign io_mem_req_valid = live_reg && (state_reg == S_REQ);
  assign io_mem_req_addr  = live_reg ? {pc_reg[31:3], 3'b000} : 32'd0;
  assign req_fire         = io_mem_req_valid && io_mem_req_ready;

  assign enq_fire           = (state_reg == S_ENQ) && io_readyForEnqueue && !io_redirect_valid;
  assign io_enqueue_0_valid = enq_fire;
  assign io_enqueue_1_valid = enq_fire && !odd_reg;
  assign io_enqueue_0_bits  = (state_reg != S_ENQ) ? 32'd0
                            : (odd_reg ? hold_reg[63:32] : hold_reg[31:0]);
  assign io_enqueue_1_bits  = (state_reg == S_ENQ && !odd_reg) ? hold_reg[63:32] : 32'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      drop_reg  <= 1'b0;
      odd_reg   <= 1'b0;
      hold_reg  <= 64'd0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      drop_reg  <= drop_next;
      odd_reg   <= odd_next;
      hold_reg  <= hold_next;
      live_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    drop_next  = drop_reg;
    odd_next   = odd_reg;
    hold_next  = hold_reg;
    if (io_redirect_valid) begin
      pc_next = {io_redirect_pc[31:2], 2'b00};
      case (state_reg)
        S_REQ: begin
          // The just-accepted request is stale; its response must be swallowed.
          if (req_fire) begin
            state_next = S_WAIT;
            drop_next  = 1'b1;
          end
        end
        S_WAIT: begin
          if (io_mem_resp_valid) begin
            state_next = S_REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_fire) begin
            odd_next   = pc_reg[2];
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_mem_resp_valid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = S_REQ;
            end else begin
              hold_next  = io_mem_resp_data;
              state_next = S_ENQ;
            end
          end
        end
        S_ENQ: begin
          if (io_readyForEnqueue) begin
            pc_next    = pc_reg + (odd_reg ? 32'd4 : 32'd8);
            state_next = S_REQ;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pair_enqueuer.sv
// Self-checking bench for fetch_pair_enqueuer: drives the memory and FIFO sides
// by hand and checks enqueued instructions against a scoreboard queue.
module tb_fetch_pair_enqueuer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_redirect_valid = 1'b0;
  logic [31:0] io_redirect_pc = 32'd0;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready = 1'b0;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid = 1'b0;
  logic [63:0] io_mem_resp_data = 64'd0;
  logic        io_readyForEnqueue = 1'b0;
  logic        io_enqueue_0_valid;
  logic [31:0] io_enqueue_0_bits;
  logic        io_enqueue_1_valid;
  logic [31:0] io_enqueue_1_bits;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic        v1;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  fetch_pair_enqueuer #(.RESET_PC(32'hBFC0_0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_mem_req_valid   (io_mem_req_valid),
    .io_mem_req_ready   (io_mem_req_ready),
    .io_mem_req_addr    (io_mem_req_addr),
    .io_mem_resp_valid  (io_mem_resp_valid),
    .io_mem_resp_data   (io_mem_resp_data),
    .io_readyForEnqueue (io_readyForEnqueue),
    .io_enqueue_0_valid (io_enqueue_0_valid),
    .io_enqueue_0_bits  (io_enqueue_0_bits),
    .io_enqueue_1_valid (io_enqueue_1_valid),
    .io_enqueue_1_bits  (io_enqueue_1_bits)
  );

  // One complete fetch of the pair containing pc, with `stall` backpressured ENQ cycles.
  task automatic do_pair(input string name, input logic [31:0] pc, input logic [63:0] data,
                         input int stall, output logic [31:0] next_pc);
    exp_t e;
    logic odd;
    odd = pc[2];
    @(negedge clock);
    io_redirect_valid = 1'b0; io_mem_resp_valid = 1'b0;
    io_mem_req_ready = 1'b1; io_readyForEnqueue = 1'b1;
    #1;
    tests++;
    if (io_mem_req_valid !== 1'b1 || io_mem_req_addr !== {pc[31:3], 3'b000} || io_enqueue_0_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_req: valid=%b addr=%h enq0=%b, required valid=1 addr=%h enq0=0",
               name, io_mem_req_valid, io_mem_req_addr, io_enqueue_0_valid, {pc[31:3], 3'b000});
    end
    @(negedge clock);
    io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b1; io_mem_resp_data = data;
    e.s0 = odd ? data[63:32] : data[31:0];
    e.s1 = odd ? 32'd0 : data[63:32];
    e.v1 = !odd;
    sb.push_back(e);
    #1;
    tests++;
    if (io_enqueue_0_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_wait: enq0=%b req_valid=%b, required 0 0", name, io_enqueue_0_valid, io_mem_req_valid);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      io_mem_resp_valid = 1'b0; io_readyForEnqueue = 1'b0;
      #1;
      tests++;
      if (io_enqueue_0_valid !== 1'b0 || io_enqueue_1_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s_stall%0d: enq0=%b enq1=%b req_valid=%b, required 0 0 0",
                 name, i, io_enqueue_0_valid, io_enqueue_1_valid, io_mem_req_valid);
      end
    end
    @(negedge clock);
    io_mem_resp_valid = 1'b0; io_readyForEnqueue = 1'b1;
    #1;
    tests++;
    if (io_enqueue_0_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_enq_valid: enq0=%b, required 1", name, io_enqueue_0_valid);
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_enq_unexpected: enqueue observed with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (io_enqueue_0_bits !== e.s0 || io_enqueue_1_valid !== e.v1 || io_enqueue_1_bits !== e.s1) begin
        fails++;
        $display("FAIL %s_enq_data: s0=%h v1=%b s1=%h, required s0=%h v1=%b s1=%h",
                 name, io_enqueue_0_bits, io_enqueue_1_valid, io_enqueue_1_bits, e.s0, e.v1, e.s1);
      end
    end
    next_pc = pc + (odd ? 32'd4 : 32'd8);
  endtask

  task automatic redirect_to(input string name, input logic [31:0] target);
    @(negedge clock);
    io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; io_readyForEnqueue = 1'b1;
    io_redirect_valid = 1'b1; io_redirect_pc = target;
    #1;
    tests++;
    if (io_mem_req_valid !== 1'b1 || io_enqueue_0_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_redirect_req: req_valid=%b enq0=%b, required 1 0", name, io_mem_req_valid, io_enqueue_0_valid);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      tests++;
      if ({io_mem_req_valid, io_mem_req_addr, io_enqueue_0_valid, io_enqueue_0_bits,
           io_enqueue_1_valid, io_enqueue_1_bits} !== 99'd0) begin
        fails++;
        $display("FAIL reset_outputs: req_valid=%b addr=%h enq0=%b/%h enq1=%b/%h, required all 0",
                 io_mem_req_valid, io_mem_req_addr, io_enqueue_0_valid, io_enqueue_0_bits,
                 io_enqueue_1_valid, io_enqueue_1_bits);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_aligned(inout logic [31:0] pc);
    do_pair("aligned0", pc, 64'h2222_2222_1111_1111, 0, pc);
    do_pair("aligned1", pc, 64'h4444_4444_3333_3333, 0, pc);
  endtask

  task automatic test_odd(inout logic [31:0] pc);
    redirect_to("odd", 32'h0000_0104);
    pc = 32'h0000_0104;
    do_pair("odd", pc, 64'hBBBB_BBBB_AAAA_AAAA, 0, pc);
    do_pair("after_odd", pc, 64'h6666_6666_5555_5555, 0, pc);
  endtask

  task automatic test_backpressure(inout logic [31:0] pc);
    do_pair("backpressure", pc, 64'h8888_8888_7777_7777, 5, pc);
    do_pair("after_bp", pc, 64'hAAAA_0000_9999_0000, 0, pc);
  endtask

  task automatic test_redirect_wait(inout logic [31:0] pc);
    @(negedge clock);
    io_redirect_valid = 1'b0; io_mem_resp_valid = 1'b0;
    io_mem_req_ready = 1'b1; io_readyForEnqueue = 1'b0;
    #1;
    tests++;
    if (io_mem_req_valid !== 1'b1 || io_mem_req_addr !== {pc[31:3], 3'b000}) begin
      fails++;
      $display("FAIL rw_req: valid=%b addr=%h, required 1 %h", io_mem_req_valid, io_mem_req_addr, {pc[31:3], 3'b000});
    end
    @(negedge clock);
    io_mem_req_ready = 1'b0; io_redirect_valid = 1'b1; io_redirect_pc = 32'h0000_0203;
    #1;
    tests++;
    if (io_enqueue_0_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rw_redirect: enq0=%b req_valid=%b, required 0 0", io_enqueue_0_valid, io_mem_req_valid);
    end
    @(negedge clock);
    io_redirect_valid = 1'b0; io_mem_resp_valid = 1'b1;
    io_mem_resp_data = 64'hDEAD_DEAD_DEAD_DEAD; io_readyForEnqueue = 1'b1;
    #1;
    tests++;
    if (io_enqueue_0_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rw_stale: enq0=%b req_valid=%b, required 0 0", io_enqueue_0_valid, io_mem_req_valid);
    end
    pc = 32'h0000_0200;
    do_pair("rw_fresh", pc, 64'hCAFE_0002_CAFE_0001, 0, pc);
  endtask

  task automatic test_wrap(inout logic [31:0] pc);
    redirect_to("wrap", 32'hFFFF_FFF8);
    pc = 32'hFFFF_FFF8;
    do_pair("wrap_last", pc, 64'h0BAD_F00D_1234_5678, 0, pc);
    do_pair("wrap_zero", pc, 64'h0000_0002_0000_0001, 0, pc);
  endtask

  task automatic test_reset_mid(inout logic [31:0] pc);
    @(negedge clock);
    io_mem_req_ready = 1'b1; io_readyForEnqueue = 1'b0;
    @(negedge clock);
    io_mem_req_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    tests++;
    if (io_mem_req_valid !== 1'b0 || io_mem_req_addr !== 32'd0 || io_enqueue_0_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: req_valid=%b addr=%h enq0=%b, required 0 0 0",
               io_mem_req_valid, io_mem_req_addr, io_enqueue_0_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    pc = 32'hBFC0_0000;
    do_pair("post_reset", pc, 64'h1357_9BDF_2468_ACE0, 0, pc);
  endtask

  initial begin
    logic [31:0] pc;
    pc = 32'hBFC0_0000;
    test_reset();
    test_aligned(pc);
    test_odd(pc);
    test_backpressure(pc);
    test_redirect_wait(pc);
    test_wrap(pc);
    test_reset_mid(pc);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
